// File: rtl/line_mem.sv
// line_mem: line-granular main-memory model behind the data cache.
// Each request moves one 128-bit line after LATENCY cycles in BUSY and
// finishes with a one-cycle mem_ready pulse.
// Optional build macro LINE_MEM_STAT_EN adds completed read/write counters;
// without it rd_cnt/wr_cnt are tied to 0.
module line_mem #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         mem_r,
    input  logic         mem_w,
    input  logic [31:0]  mem_addr,
    input  logic [127:0] mem_w_data,
    output logic [127:0] mem_r_data,
    output logic         mem_ready,
    output logic [31:0]  rd_cnt,
    output logic [31:0]  wr_cnt
);

    localparam int          LINES    = 1 << ADDR_WIDTH;
    localparam logic [7:0]  CNT_LOAD = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [7:0]              cnt;
    logic                    op_write;
    logic [ADDR_WIDTH-1:0]   line_idx;
    logic [127:0]            line_data;
    logic                    accept;
    logic                    commit;

    // Not reset: contents must survive rstn.
    logic [127:0]            storage [LINES];

    // Offset bits and bits above the index are ignored, so upper bits alias.
    logic unused_addr;
    assign unused_addr = ^{mem_addr[31:ADDR_WIDTH+4], mem_addr[3:0]};

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state: requests only matter in IDLE, DONE always returns to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (mem_r || mem_w) state_next = BUSY;
            BUSY:    if (cnt == 8'd0)    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output/strobe decode: accept in IDLE, commit on the BUSY->DONE edge.
    always_comb begin
        accept = 1'b0;
        commit = 1'b0;
        case (state)
            IDLE:    accept = mem_r || mem_w;
            BUSY:    commit = (cnt == 8'd0);
            default: ;
        endcase
    end

    // Request latch and latency countdown; a write wins over a read.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt       <= 8'd0;
            op_write  <= 1'b0;
            line_idx  <= '0;
            line_data <= '0;
        end else if (accept) begin
            cnt       <= CNT_LOAD;
            op_write  <= mem_w;
            line_idx  <= mem_addr[ADDR_WIDTH+3:4];
            line_data <= mem_w_data;
        end else if (state == BUSY && cnt != 8'd0) begin
            cnt       <= cnt - 8'd1;
        end
    end

    // Array write port; only a committed write touches the storage.
    always_ff @(posedge clk) begin
        if (commit && op_write) storage[line_idx] <= line_data;
    end

    // Read data and completion pulse; mem_ready is high exactly in DONE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_r_data <= '0;
            mem_ready  <= 1'b0;
        end else begin
            mem_ready <= commit;
            if (commit && !op_write) mem_r_data <= storage[line_idx];
        end
    end

`ifdef LINE_MEM_STAT_EN
    // Completed-transaction counters, bumped on the commit edge, wrap mod 2^32.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_cnt <= 32'd0;
            wr_cnt <= 32'd0;
        end else if (commit) begin
            if (op_write) wr_cnt <= wr_cnt + 32'd1;
            else          rd_cnt <= rd_cnt + 32'd1;
        end
    end
`else
    assign rd_cnt = 32'd0;
    assign wr_cnt = 32'd0;
`endif

endmodule
